// File: rtl/alu_sel_pkg.sv
// alu_sel_pkg: shared definitions for the registered ALU result selector.
//   sel_state_t      : occupancy of the two-entry output buffer.
//   ZERO_BIT/ERR_BIT : payload flag positions for the default 8-bit result.
//   zero_bit/err_bit : the same positions for any result width. The payload
//                      is {err, zero, value[WIDTH-1:0]}.
package alu_sel_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } sel_state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int ZERO_BIT      = WIDTH_DEFAULT;
  localparam int ERR_BIT       = WIDTH_DEFAULT + 1;

  function automatic int zero_bit(input int width);
    return width;
  endfunction

  function automatic int err_bit(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/result_skid.sv
// result_skid: two-entry skid buffer on a valid/ready stream.
//   clk, rst     : clock, synchronous active-high reset
//   in_payload   : W-bit beat offered by the producer
//   in_valid     : producer has a beat
//   in_ready     : buffer can take a beat (registered decode only)
//   out_payload  : W-bit beat held in the main register M
//   out_valid    : M holds a beat
//   out_ready    : consumer takes the beat
//   state        : current buffer occupancy (debug)
//
// Handshake: a beat moves on a cycle where valid and ready are both high on
// that side. Once out_valid is high, out_payload stays fixed until a cycle
// with out_ready high. in_ready depends on the state register only, so there
// is no combinational path from out_ready to in_ready. The skid register S
// catches the beat accepted in the cycle the consumer stalls.
module result_skid
  import alu_sel_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_payload,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   state
);

  sel_state_t   state_q;
  sel_state_t   state_d;
  logic [W-1:0] m_q;
  logic [W-1:0] s_q;
  logic         accept;
  logic         deliver;
  logic         load_m_in;
  logic         load_m_skid;
  logic         load_s;

  assign in_ready    = (state_q != TWO);
  assign out_valid   = (state_q != EMPTY);
  assign out_payload = m_q;
  assign state       = state_q;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load_m_in = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          load_s  = 1'b1;
          state_d = TWO;
        end else if (!accept && deliver) begin
          state_d = EMPTY;
        end else if (accept && deliver) begin
          // M drains and refills on the same edge; occupancy unchanged.
          load_m_in = 1'b1;
        end
      end
      TWO: begin
        if (deliver) begin
          load_m_skid = 1'b1;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load_m_in) begin
        m_q <= in_payload;
      end else if (load_m_skid) begin
        m_q <= s_q;
      end
      if (load_s) begin
        s_q <= in_payload;
      end
    end
  end

endmodule

// File: rtl/alu_result_sel.sv
// alu_result_sel: selects one of NUM_IN results, tags it with zero and
// out-of-range flags, and presents it on a buffered valid/ready stream.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : NUM_IN results, input k at [k*WIDTH +: WIDTH]
//   sel        : input index
//   enable     : 0 forces the selected value to 0
//   in_valid   : request qualifier for in_data/sel/enable
//   in_ready   : request can be accepted
//   out_data   : registered result
//   out_zero   : out_data == 0
//   out_err    : request had sel >= NUM_IN
//   out_valid  : output beat valid
//   out_ready  : consumer accepts the beat
//   dbg_state  : buffer occupancy (EMPTY/ONE/TWO)
module alu_result_sel
  import alu_sel_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              dbg_state
);

  localparam int PW = WIDTH + 2;
  localparam int ZB = zero_bit(WIDTH);
  localparam int EB = err_bit(WIDTH);

  logic [31:0]      sel_ext;
  logic [WIDTH-1:0] value;
  logic             err;
  logic             zero;
  logic [PW-1:0]    payload;
  logic [PW-1:0]    out_payload;

  assign sel_ext = 32'(sel);

  // The range check only fires when NUM_IN is not a power of two; enable=0
  // suppresses both the value and the error.
  always_comb begin
    value = '0;
    err   = 1'b0;
    if (enable) begin
      if (sel_ext >= 32'(NUM_IN)) begin
        err = 1'b1;
      end else begin
        for (int k = 0; k < NUM_IN; k++) begin
          if (sel_ext == 32'(k)) begin
            value = in_data[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign zero = (value == '0);

  always_comb begin
    payload            = '0;
    payload[WIDTH-1:0] = value;
    payload[ZB]        = zero;
    payload[EB]        = err;
  end

  result_skid #(
    .W (PW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_payload  (payload),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_payload (out_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state       (dbg_state)
  );

  assign out_data = out_payload[WIDTH-1:0];
  assign out_zero = out_payload[ZB];
  assign out_err  = out_payload[EB];

endmodule

// File: tb/tb_alu_result_sel.sv
module tb_alu_result_sel;
  import alu_sel_pkg::*;

  localparam int PW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut_a: WIDTH=8, NUM_IN=16
  logic [127:0] a_in_data = '0;
  logic [3:0]   a_sel = '0;
  logic         a_enable = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic         a_in_ready, a_out_zero, a_out_err, a_out_valid;
  logic [7:0]   a_out_data;
  logic [1:0]   a_dbg;
  // dut_b: WIDTH=8, NUM_IN=10
  logic [79:0]  b_in_data = '0;
  logic [3:0]   b_sel = '0;
  logic         b_enable = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic         b_in_ready, b_out_zero, b_out_err, b_out_valid;
  logic [7:0]   b_out_data;
  logic [1:0]   b_dbg;
  // dut_c: WIDTH=12, NUM_IN=5
  logic [59:0]  c_in_data = '0;
  logic [2:0]   c_sel = '0;
  logic         c_enable = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b1;
  logic         c_in_ready, c_out_zero, c_out_err, c_out_valid;
  logic [11:0]  c_out_data;
  logic [1:0]   c_dbg;

  alu_result_sel #(.WIDTH(8), .NUM_IN(16)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel), .enable(a_enable),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_zero(a_out_zero), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .dbg_state(a_dbg));

  alu_result_sel #(.WIDTH(8), .NUM_IN(10)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel), .enable(b_enable),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_zero(b_out_zero), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .dbg_state(b_dbg));

  alu_result_sel #(.WIDTH(12), .NUM_IN(5)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .sel(c_sel), .enable(c_enable),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_zero(c_out_zero), .out_err(c_out_err), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .dbg_state(c_dbg));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: payload {err, zero, value} laid out at bit width+1, width, 0.
  function automatic logic [PW-1:0] model(input logic [255:0] flat, input int width,
                                          input int num_in, input int s, input bit en);
    logic [11:0]  v;
    logic [255:0] mask;
    bit           e;
    v    = '0;
    e    = 1'b0;
    mask = (256'(1) << width) - 256'(1);
    if (en) begin
      if (s >= num_in) e = 1'b1;
      else v = 12'((flat >> (s * width)) & mask);
    end
    return PW'(v) | (PW'(v == 12'd0) << width) | (PW'(e) << (width + 1));
  endfunction

  // ---------------- scoreboards ----------------
  logic [PW-1:0] a_q[$];
  logic [PW-1:0] c_q[$];
  int            a_deliv = 0, c_deliv = 0;
  logic          a_hold = 1'b0, c_hold = 1'b0;
  logic [PW-1:0] a_prev, c_prev, a_pay, c_pay;

  always @(negedge clk) begin
    a_pay = {4'b0, a_out_err, a_out_zero, a_out_data};
    if (rst) begin
      a_q.delete();
      a_hold = 1'b0;
    end else begin
      if (a_hold) check("a_stall_stable", {15'b0, a_out_valid, 2'b0, a_pay}, {15'b0, 1'b1, 2'b0, a_prev});
      if (a_out_valid && a_out_ready) begin
        a_deliv++;
        if (a_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_beat: got %0h expected no beat", a_pay);
        end else begin
          check("a_order", 32'(a_pay), 32'(a_q.pop_front()));
        end
      end
      if (a_in_valid && a_in_ready)
        a_q.push_back(model(256'(a_in_data), 8, 16, int'(a_sel), a_enable));
      a_hold = a_out_valid && !a_out_ready;
      a_prev = a_pay;
    end
  end

  always @(negedge clk) begin
    c_pay = {c_out_err, c_out_zero, c_out_data};
    if (rst) begin
      c_q.delete();
      c_hold = 1'b0;
    end else begin
      if (c_hold) check("c_stall_stable", {17'b0, c_out_valid, c_pay}, {17'b0, 1'b1, c_prev});
      if (c_out_valid && c_out_ready) begin
        c_deliv++;
        if (c_q.size() == 0) begin
          total++; bad++;
          $display("FAIL c_unexpected_beat: got %0h expected no beat", c_pay);
        end else begin
          check("c_order", 32'(c_pay), 32'(c_q.pop_front()));
        end
      end
      if (c_in_valid && c_in_ready)
        c_q.push_back(model(256'(c_in_data), 12, 5, int'(c_sel), c_enable));
      c_hold = c_out_valid && !c_out_ready;
      c_prev = c_pay;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_a(input logic [7:0] v);
    a_in_data      = {$urandom, $urandom, $urandom, $urandom};
    a_in_data[7:0] = v;
    a_sel          = 4'd0;
    a_enable       = 1'b1;
    a_in_valid     = 1'b1;
  endtask

  typedef struct {
    bit         use_b;
    logic [7:0] sel;
    bit         enable;
    logic [7:0] val;
    logic [7:0] exp_data;
    bit         exp_zero;
    bit         exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    if (!v.use_b) begin
      a_in_data = {$urandom, $urandom, $urandom, $urandom};
      a_in_data[int'(v.sel)*8 +: 8] = v.val;
      a_sel = v.sel[3:0]; a_enable = v.enable; a_in_valid = 1'b1;
    end else begin
      b_in_data = 80'({$urandom, $urandom, $urandom});
      if (v.sel < 8'd10) b_in_data[int'(v.sel)*8 +: 8] = v.val;
      b_sel = v.sel[3:0]; b_enable = v.enable; b_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(negedge clk);
    if (!v.use_b) begin
      check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
      check({tag, "_data"},  32'(a_out_data),  32'(v.exp_data));
      check({tag, "_zero"},  32'(a_out_zero),  32'(v.exp_zero));
      check({tag, "_err"},   32'(a_out_err),   32'(v.exp_err));
    end else begin
      check({tag, "_valid"}, 32'(b_out_valid), 32'd1);
      check({tag, "_data"},  32'(b_out_data),  32'(v.exp_data));
      check({tag, "_zero"},  32'(b_out_zero),  32'(v.exp_zero));
      check({tag, "_err"},   32'(b_out_err),   32'(v.exp_err));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_one_cycle"}, 32'(v.use_b ? b_out_valid : a_out_valid), 32'd0);
  endtask

  logic c_took = 1'b0;
  int   saved;

  initial begin
    tbl[0] = '{1'b0, 8'd5,  1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd3,  1'b0, 8'hFF, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd15, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'd0,  1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'd12, 1'b1, 8'hAA, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 8'd9,  1'b1, 8'h7E, 8'h7E, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'd12, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0};

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_out_data",  32'(a_out_data),  32'd0);
    check("rst_out_zero",  32'(a_out_zero),  32'd0);
    check("rst_out_err",   32'(a_out_err),   32'd0);
    check("rst_state_a",   32'(a_dbg), 32'(EMPTY));
    check("rst_state_b",   32'(b_dbg), 32'(EMPTY));
    check("rst_state_c",   32'(c_dbg), 32'(EMPTY));

    // ---- table vectors ----
    for (int i = 0; i < 7; i++) apply_vec(tbl[i], i);

    // ---- full-rate burst ----
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive_a(8'($urandom_range(0, 255)));
      @(negedge clk);
      check("burst_in_ready", 32'(a_in_ready), 32'd1);
      if (i > 0) check("burst_out_valid", 32'(a_out_valid), 32'd1);
    end
    @(posedge clk); #1 a_in_valid = 1'b0;
    repeat (3) @(posedge clk);

    // ---- backpressure 1,2,3,4 ----
    saved = a_deliv;
    @(posedge clk); #1; a_out_ready = 1'b0; drive_a(8'd1);
    @(negedge clk); check("bp_ready_1", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1; drive_a(8'd2);
    @(negedge clk);
    check("bp_ready_2", 32'(a_in_ready), 32'd1);
    check("bp_head_1",  32'(a_out_data), 32'd1);
    @(posedge clk); #1; drive_a(8'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_in_ready", 32'(a_in_ready),  32'd0);
      check("bp_full_hold",     32'(a_out_data),  32'd1);
      check("bp_full_valid",    32'(a_out_valid), 32'd1);
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; a_out_ready = 1'b1;
    @(negedge clk); check("bp_exit_lag", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_exit_ready", 32'(a_in_ready), 32'd1);
    check("bp_seq_2",      32'(a_out_data), 32'd2);
    @(posedge clk); #1; drive_a(8'd4);
    @(negedge clk);
    check("bp_seq_3", 32'(a_out_data), 32'd3);
    check("bp_ready_4", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(negedge clk);
    check("bp_seq_4",   32'(a_out_data),  32'd4);
    check("bp_valid_4", 32'(a_out_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained", 32'(a_out_valid), 32'd0);
    check("bp_count",   32'(a_deliv - saved), 32'd4);

    // ---- reset with two beats buffered ----
    @(posedge clk); #1; a_out_ready = 1'b0; drive_a(8'h55);
    @(posedge clk); #1; drive_a(8'h66);
    @(posedge clk); #1; a_in_valid = 1'b0;
    @(negedge clk); check("mrst_full", 32'(a_in_ready), 32'd0);
    saved = a_deliv;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 32'(a_out_valid), 32'd0);
    check("mrst_in_ready",  32'(a_in_ready),  32'd1);
    check("mrst_out_data",  32'(a_out_data),  32'd0);
    @(posedge clk); #1; a_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_no_beats", 32'(a_deliv - saved), 32'd0);

    // ---- reset overrides accept on the same edge ----
    @(posedge clk); #1; rst = 1'b1; drive_a(8'h77);
    @(posedge clk); #1; rst = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("rst_vs_accept", 32'(a_out_valid), 32'd0);
    repeat (2) @(posedge clk);

    // ---- random stress on dut_c ----
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (!c_in_valid || c_took) begin
        c_in_valid = ($urandom_range(0, 3) != 0);
        c_in_data  = 60'({$urandom, $urandom});
        c_sel      = 3'($urandom_range(0, 7));
        c_enable   = ($urandom_range(0, 7) != 0);
      end
      c_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      c_took = c_in_valid && c_in_ready;
    end
    @(posedge clk); #1;
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("c_q_empty",   32'(c_q.size()), 32'd0);
    check("c_activity",  32'(c_deliv > 2000), 32'd1);
    check("a_q_empty",   32'(a_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
